stream_mux_rr: RTL and testbench

//  Parametrised N:1 selector for W-bit data channels. Generalises the 2:1 select

---
 rtl/stream_mux_rr_pkg.sv | 10 +
 rtl/stream_mux_rr_arbiter.sv | 30 +++
 rtl/stream_mux_rr.sv | 102 ++++++++++
 tb/tb_stream_mux_rr.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the stream_mux_rr selector and its arbiter.
package stream_mux_rr_pkg;

    // Channel-selection mode as driven on the mode input.
    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: the requesting channel closest after ptr
// (wrapping modulo CHANNELS) wins. ptr itself has the lowest priority.
module rr_arbiter #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    grant,
    output logic                grant_valid
);

    // Pick the requester with the smallest forward distance from ptr+1.
    always_comb begin
        int unsigned best_d;
        int unsigned d;
        grant       = '0;
        grant_valid = 1'b0;
        best_d      = CHANNELS;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            d = (i + 2 * CHANNELS - 1 - 32'(ptr)) % CHANNELS;
            if (req[i] && d < best_d) begin
                best_d      = d;
                grant       = SEL_W'(i);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 stream selector with fixed-select and round-robin modes, valid/ready
// handshake on every channel and a single registered output stage.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          beat_cnt
);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_valid;
    logic [SEL_W-1:0] fix_grant;
    logic             fix_valid;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             load;
    logic             accept;
    logic [WIDTH-1:0] grant_data;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_arbiter (
        .req         (in_valid),
        .ptr         (rr_ptr),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    // Fixed-mode grant; an out-of-range sel matches no channel and grants nothing.
    always_comb begin
        fix_grant = '0;
        fix_valid = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (32'(sel) == i && in_valid[i]) begin
                fix_grant = SEL_W'(i);
                fix_valid = 1'b1;
            end
        end
    end

    // Mode mux, handshake and the data path into the output register.
    always_comb begin
        if (mode == MODE_RR) begin
            grant       = rr_grant;
            grant_valid = rr_valid;
        end else begin
            grant       = fix_grant;
            grant_valid = fix_valid;
        end
        load       = !out_valid || out_ready;
        accept     = load && grant_valid;
        grant_data = '0;
        in_ready   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = rst_n && accept;
            end
        end
    end

    // Output register, accepted-beat counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            beat_cnt  <= '0;
            rr_ptr    <= SEL_W'(CHANNELS - 1);
        end else if (load) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_chan  <= grant;
                beat_cnt  <= beat_cnt + 1'b1;
                if (mode == MODE_RR) begin
                    rr_ptr <= grant;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed and randomized bench for stream_mux_rr with a beat-level reference
// model and an end-to-end scoreboard of accepted beats.
module tb_stream_mux_rr;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SW = 3;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_chan;
    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   beat_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_valid;
    logic [W-1:0] m_data;
    int          m_chan;
    int          m_cnt;
    int          m_last;
    logic [10:0] sb[$];

    always #5 clk = ~clk;

    stream_mux_rr #(
        .WIDTH    (W),
        .CHANNELS (N),
        .SEL_W    (SW),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .beat_cnt  (beat_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_data  = '0;
        m_chan  = 0;
        m_cnt   = 0;
        m_last  = N - 1;
        sb.delete();
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        int          g;
        bit          gv;
        bit          ld;
        bit          v[N];
        int          s;
        int          c;
        logic [N-1:0] exp_rdy;
        logic [10:0] e;
        #1;
        for (int i = 0; i < N; i++) v[i] = in_valid[i];
        gv = 0;
        g  = 0;
        if (mode == 1'b0) begin
            s = int'(sel);
            if (s < N && v[s]) begin
                gv = 1;
                g  = s;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!gv && v[c]) begin
                    gv = 1;
                    g  = c;
                end
            end
        end
        ld      = !m_valid || out_ready;
        exp_rdy = (ld && gv) ? (N'(1) << g) : '0;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (m_valid && out_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_beat", 32'({out_chan, out_data}), 32'(e));
            end
        end
        @(posedge clk);
        if (ld) begin
            if (gv) begin
                m_valid = 1;
                m_data  = in_data[g*W +: W];
                m_chan  = g;
                m_cnt   = (m_cnt + 1) % (1 << CW);
                if (mode == 1'b1) m_last = g;
                sb.push_back({3'(g), m_data});
            end else begin
                m_valid = 0;
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_chan",  32'(out_chan),  32'(m_chan));
        chk("beat_cnt",  32'(beat_cnt),  32'(m_cnt));
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle, checks the immediate effect, releases on a falling edge.
    task automatic do_reset();
        in_valid  = '1;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_beat_cnt",  32'(beat_cnt),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_chan",  32'(out_chan),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] held;
        rst_n     = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Fixed select of channel 2, then an out-of-range select.
        mode      = 1'b0;
        sel       = 3'd2;
        in_valid  = 4'b1111;
        in_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
        out_ready = 1'b1;
        step();
        chk("fix_data", 32'(out_data), 32'hA5);
        chk("fix_chan", 32'(out_chan), 32'd2);
        sel = 3'd5;
        step();
        chk("fix_oob_valid", 32'(out_valid), 32'd0);

        // Reset while a beat is pending.
        sel = 3'd1;
        step();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        do_reset();

        // Round-robin fairness with every channel requesting.
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = $urandom;
            step();
            chk("rr_seq", 32'(out_chan), 32'(i % N));
        end
        chk("rr_cnt8", 32'(beat_cnt), 32'd8);

        // Round-robin skips idle channels.
        in_valid = 4'b0010;
        step();
        chk("skip_ch1", 32'(out_chan), 32'd1);
        in_valid = 4'b1010;
        step();
        chk("skip_ch3", 32'(out_chan), 32'd3);
        step();
        chk("skip_ch1b", 32'(out_chan), 32'd1);

        // Backpressure: hold for three cycles, then drain and refill together.
        in_valid = 4'b1111;
        in_data  = $urandom;
        step();
        held      = out_data;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 4'($urandom);
            in_data  = $urandom;
            step();
            chk("bp_hold", 32'(out_data), 32'(held));
        end
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        in_data   = $urandom;
        step();
        chk("bp_refill_valid", 32'(out_valid), 32'd1);

        // Counter wrap on a 4-bit counter.
        do_reset();
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = $urandom;
            step();
        end
        chk("cnt_wrap", 32'(beat_cnt), 32'd1);

        // Mode switch mid-stream with random backpressure.
        for (int i = 0; i < 12; i++) begin
            if (i == 6) mode = 1'b0;
            sel       = 3'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            sel       = 3'($urandom_range(0, 7));
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        chk("sb_residue", 32'(sb.size()), 32'(m_valid ? 1 : 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
